// File: rtl/ip_tile_scheduler.sv
// ip_tile_scheduler: round-robin front end that serialises two requesters onto one compute tile.
// Optional watchdog is compiled in when IP_TILE_SCHED_TIMEOUT_EN is defined.
module ip_tile_scheduler #(
  parameter int REG_WIDTH      = 32,
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 rq_req,
  input  logic [2*CSR_IN_WIDTH-1:0]  rq_csr,
  input  logic [2*REG_WIDTH-1:0]     rq_a,
  input  logic [2*REG_WIDTH-1:0]     rq_b,
  output logic [1:0]                 rq_gnt,
  output logic [CSR_IN_WIDTH-1:0]    tile_csr_in,
  output logic [REG_WIDTH-1:0]       tile_a,
  output logic [REG_WIDTH-1:0]       tile_b,
  input  logic [REG_WIDTH-1:0]       tile_c,
  input  logic [CSR_OUT_WIDTH-1:0]   tile_csr_out,
  input  logic                       tile_csr_in_re,
  input  logic                       tile_csr_out_we,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [REG_WIDTH-1:0]       rsp_data,
  output logic [CSR_OUT_WIDTH-1:0]   rsp_csr,
  output logic                       rsp_timeout,
  output logic                       busy
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("ip_tile_scheduler: TIMEOUT_CYCLES must be within 1..255");
  end

  localparam logic [CSR_IN_WIDTH-1:0] START_BIT = {{(CSR_IN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                    state_q;
  logic [1:0]                gnt_q;
  logic                      last_q;
  logic                      rsp_valid_q;
  logic                      rsp_id_q;
  logic                      busy_q;
  logic [CSR_IN_WIDTH-1:0]   tcsr_q;
  logic [REG_WIDTH-1:0]      a_q;
  logic [REG_WIDTH-1:0]      b_q;
  logic [REG_WIDTH-1:0]      data_q;
  logic [CSR_OUT_WIDTH-1:0]  csr_q;

  logic                      win_id_d;
  logic [CSR_IN_WIDTH-1:0]   cmd_d;
  logic [REG_WIDTH-1:0]      a_d;
  logic [REG_WIDTH-1:0]      b_d;
  logic                      take_d;
  logic                      tmo_hit_d;

  // Round-robin pick: a lone request wins outright, a tie goes to the one not served last.
  always_comb begin
    win_id_d = 1'b0;
    if (rq_req == 2'b11) begin
      win_id_d = ~last_q;
    end else if (rq_req[1]) begin
      win_id_d = 1'b1;
    end else begin
      win_id_d = 1'b0;
    end
  end

  // Payload slice of the winning requester.
  always_comb begin
    cmd_d = rq_csr[CSR_IN_WIDTH-1:0];
    a_d   = rq_a[REG_WIDTH-1:0];
    b_d   = rq_b[REG_WIDTH-1:0];
    if (win_id_d) begin
      cmd_d = rq_csr[2*CSR_IN_WIDTH-1:CSR_IN_WIDTH];
      a_d   = rq_a[2*REG_WIDTH-1:REG_WIDTH];
      b_d   = rq_b[2*REG_WIDTH-1:REG_WIDTH];
    end else begin
      cmd_d = rq_csr[CSR_IN_WIDTH-1:0];
      a_d   = rq_a[REG_WIDTH-1:0];
      b_d   = rq_b[REG_WIDTH-1:0];
    end
  end

  // A result is only taken once the tile has consumed the command (same cycle or later).
  assign take_d = tile_csr_out_we &&
                  ((state_q == S_WAIT) || ((state_q == S_ISSUE) && tile_csr_in_re));

`ifdef IP_TILE_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = TIMEOUT_CYCLES[7:0];

  logic [7:0] tmo_q;
  logic       rsp_timeout_q;

  assign tmo_hit_d = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                     ((tmo_q + 8'd1) == TMO_LIMIT);

  // Watchdog: zero while idle so it starts from 0 on ISSUE entry, counts ISSUE/WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 8'd0;
    end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      tmo_q <= tmo_q + 8'd1;
    end else begin
      tmo_q <= 8'd0;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign tmo_hit_d   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Scheduler FSM; the grant cycle is spent in IDLE with gnt_q set, ISSUE follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      tcsr_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      csr_q       <= '0;
`ifdef IP_TILE_SCHED_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      gnt_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
`ifdef IP_TILE_SCHED_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (gnt_q != 2'b00) begin
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            tcsr_q  <= tcsr_q | START_BIT;
          end else if (rq_req != 2'b00) begin
            gnt_q    <= win_id_d ? 2'b10 : 2'b01;
            last_q   <= win_id_d;
            rsp_id_q <= win_id_d;
            tcsr_q   <= cmd_d & ~START_BIT;
            a_q      <= a_d;
            b_q      <= b_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (take_d) begin
            data_q      <= tile_c;
            csr_q       <= tile_csr_out;
            rsp_valid_q <= 1'b1;
            tcsr_q      <= tcsr_q & ~START_BIT;
            state_q     <= S_RESP;
          end else if (tmo_hit_d) begin
            data_q      <= '0;
            csr_q       <= '0;
            rsp_valid_q <= 1'b1;
            tcsr_q      <= tcsr_q & ~START_BIT;
            state_q     <= S_RESP;
`ifdef IP_TILE_SCHED_TIMEOUT_EN
            rsp_timeout_q <= 1'b1;
`endif
          end else if ((state_q == S_ISSUE) && tile_csr_in_re) begin
            tcsr_q  <= tcsr_q & ~START_BIT;
            state_q <= S_WAIT;
          end else begin
            state_q <= state_q;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          tcsr_q  <= tcsr_q & ~START_BIT;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rq_gnt      = gnt_q;
  assign tile_csr_in = tcsr_q;
  assign tile_a      = a_q;
  assign tile_b      = b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = data_q;
  assign rsp_csr     = csr_q;
  assign busy        = busy_q;

endmodule

// File: doc/ip_tile_scheduler.md
IP_TILE_SCHEDULER -- requirements
Module: ip_tile_scheduler

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter CSR_IN_WIDTH, default 16, command word width.
REQ-003 SHALL have parameter CSR_OUT_WIDTH, default 16, status word width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (8-bit counter, legal range 1..255).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rq_req, input, 2, request per requester (bit i = requester i).
REQ-008 SHALL have port rq_csr, input, 2*CSR_IN_WIDTH, command per requester (slice i).
REQ-009 SHALL have port rq_a, input, 2*REG_WIDTH, operand A per requester.
REQ-010 SHALL have port rq_b, input, 2*REG_WIDTH, operand B per requester.
REQ-011 SHALL have port rq_gnt, output, 2, one-cycle grant/accept pulse per requester.
REQ-012 SHALL have port tile_csr_in, output, CSR_IN_WIDTH, command to tile; bit 0 is the start bit.
REQ-013 SHALL have ports tile_a and tile_b, output, REG_WIDTH each, tile operands.
REQ-014 SHALL have ports tile_c, input, REG_WIDTH, and tile_csr_out, input, CSR_OUT_WIDTH, tile result and status.
REQ-015 SHALL have ports tile_csr_in_re, input, 1, tile consumed command; and tile_csr_out_we, input, 1, tile result valid.
REQ-016 SHALL have ports rsp_valid, output, 1; rsp_id, output, 1; rsp_data, output, REG_WIDTH; rsp_csr, output, CSR_OUT_WIDTH; rsp_timeout, output, 1; busy, output, 1.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-018 IDLE with any rq_req bit set SHALL grant one requester: only one set -> that one; both set -> the one not granted last (round-robin).
REQ-019 Grant cycle SHALL pulse rq_gnt[i] for exactly one cycle, latch rq_csr/rq_a/rq_b slice i and i into rsp_id register, and enter ISSUE next cycle.
REQ-020 Requester SHALL hold request data stable until rq_gnt; rq_req still high in the cycle after rq_gnt SHALL be treated as a new request.
REQ-021 ISSUE SHALL drive tile_csr_in = latched command with bit 0 forced 1; all other states drive bit 0 = 0 with upper bits holding the latched command.
REQ-022 tile_a/tile_b SHALL hold latched operands from grant until next grant.
REQ-023 ISSUE with tile_csr_in_re = 1 SHALL go to WAIT; if tile_csr_out_we = 1 in that same cycle, result SHALL be captured and FSM SHALL go directly to RESP.
REQ-024 WAIT with tile_csr_out_we = 1 SHALL capture tile_c into rsp_data, tile_csr_out into rsp_csr, go to RESP.
REQ-025 RESP SHALL assert rsp_valid for exactly one cycle with rsp_id/rsp_data/rsp_csr stable, then return to IDLE; rsp_data/rsp_csr hold until next capture.
REQ-026 tile_csr_in_re outside ISSUE and tile_csr_out_we in IDLE/RESP SHALL be ignored.
REQ-027 busy SHALL be 1 in ISSUE, WAIT, RESP; 0 in IDLE.
REQ-028 Minimum latency: grant cycle N, ISSUE N+1, with immediate re+we at N+1 rsp_valid at N+2; next grant no earlier than N+3.

Reset
REQ-029 rst SHALL force IDLE; rq_gnt, rsp_valid, rsp_id, rsp_timeout, busy, tile_csr_in, tile_a, tile_b, rsp_data, rsp_csr = 0; round-robin state set so requester 0 wins first tie.
REQ-030 rst mid-transaction SHALL drop it silently: no rsp_valid, no grant, start bit 0 from the next cycle.

Configuration
REQ-031 With macro IP_TILE_SCHED_TIMEOUT_EN defined, a counter SHALL clear on ISSUE entry, increment each ISSUE/WAIT cycle, and on reaching TIMEOUT_CYCLES go to RESP with rsp_timeout = 1, rsp_data = 0, rsp_csr = 0; rsp_timeout is 0 on normal responses.
REQ-032 Without IP_TILE_SCHED_TIMEOUT_EN, no counter SHALL exist, rsp_timeout SHALL be tied 0, and WAIT/ISSUE SHALL wait indefinitely.

Verification
REQ-033 Single request: rq_req=01, rq_a=5, rq_b=7, csr=0x0010; tile re next cycle, we 3 cycles later with tile_c=12, csr_out=0x0001 -> gnt=01 one cycle, tile_csr_in=0x0011 during ISSUE, rsp_valid one cycle with id=0, data=12, csr=0x0001.
REQ-034 Contention: rq_req=11 held continuously -> grants alternate 01,10,01,10; rsp_id sequence 0,1,0,1.
REQ-035 Same-cycle re+we in ISSUE with tile_c=0xDEADBEEF -> WAIT skipped, rsp_valid one cycle after ISSUE, data=0xDEADBEEF.
REQ-036 rst pulsed during WAIT -> no rsp_valid, busy=0 and tile_csr_in=0 next cycle; subsequent rq_req=11 granted to requester 0 first.
REQ-037 With IP_TILE_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=4, tile never responds -> rsp_valid with rsp_timeout=1, data=0, after 4 ISSUE/WAIT cycles; without macro, busy stays 1 for 1000 cycles.
REQ-038 Spurious tile_csr_out_we=1 in IDLE -> no rsp_valid, rsp_data unchanged.
